// File: rtl/led_pwm_bank_if.sv
// Write bus between the soft-processor GPO/IO block and led_pwm_bank.
//   master: drives wr_en / wr_addr / wr_mode / wr_duty and receives wr_ack / wr_err.
//   slave : the LED bank. wr_ack pulses once per wr_en. wr_err pulses with wr_ack
//           when the address names a channel that does not exist.
interface led_pwm_bank_if #(
    parameter int ADDR_W = 4,
    parameter int DUTY_W = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_mode;
    logic [DUTY_W-1:0] wr_duty;
    logic              wr_ack;
    logic              wr_err;

    modport master (
        output wr_en, wr_addr, wr_mode, wr_duty,
        input  wr_ack, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_mode, wr_duty,
        output wr_ack, wr_err
    );
endinterface

// File: rtl/led_pwm_bank.sv
// led_pwm_bank: CHANNELS independent LED drivers, each one OFF, ON, PWM-dimmed or blinking.
//
// Ports
//   clk    system clock (50 MHz)
//   rst_n  asynchronous active-low reset; clears every register, including a pending ack
//   bus    write port (slave modport of led_pwm_bank_if): wr_en/wr_addr/wr_mode/wr_duty in,
//          wr_ack/wr_err out, both registered one cycle after wr_en
//   led    registered active-high LED drive, one bit per channel
//
// Build option
//   LED_SHADOW_EN  defined  : writes land in shadow registers, and all channels copy their
//                             shadow settings to the active ones together at the PWM period
//                             boundary (wrap). Updates are then glitch-free.
//                  undefined: writes go straight to the active registers.
//
// Timing chain: a prescaler produces tick every PRESCALE clocks. The DUTY_W-bit PWM
// counter advances on tick. wrap is the tick that takes the counter from all-ones to 0.
module led_pwm_bank #(
    parameter int CHANNELS = 8,
    parameter int ADDR_W   = 4,
    parameter int DUTY_W   = 8,
    parameter int PRESCALE = 195
) (
    input  logic                clk,
    input  logic                rst_n,
    led_pwm_bank_if.slave       bus,
    output logic [CHANNELS-1:0] led
);

    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_PWM   = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [DUTY_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [CHANNELS-1:0] led_q, led_d;
    logic [CHANNELS-1:0] blink_st_q, blink_st_d;
    mode_e               act_mode_q [CHANNELS];
    mode_e               act_mode_d [CHANNELS];
    logic [DUTY_W-1:0]   act_duty_q [CHANNELS];
    logic [DUTY_W-1:0]   act_duty_d [CHANNELS];
    logic [DUTY_W-1:0]   blink_cnt_q [CHANNELS];
    logic [DUTY_W-1:0]   blink_cnt_d [CHANNELS];
`ifdef LED_SHADOW_EN
    mode_e               shd_mode_q [CHANNELS];
    mode_e               shd_mode_d [CHANNELS];
    logic [DUTY_W-1:0]   shd_duty_q [CHANNELS];
    logic [DUTY_W-1:0]   shd_duty_d [CHANNELS];
`endif

    logic tick;
    logic wrap;
    logic addr_ok;
    logic wr_sel;

    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        wrap      = tick && (&pwm_cnt_q);
        presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
        pwm_cnt_d = tick ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;

        // Extra bit keeps the compare exact when CHANNELS == 2**ADDR_W.
        addr_ok = ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(CHANNELS));
        ack_d   = bus.wr_en;
        err_d   = bus.wr_en && !addr_ok;

        wr_sel     = 1'b0;
        led_d      = '0;
        blink_st_d = blink_st_q;

        for (int i = 0; i < CHANNELS; i++) begin
            wr_sel = bus.wr_en && addr_ok && (bus.wr_addr == ADDR_W'(i));

            act_mode_d[i]  = act_mode_q[i];
            act_duty_d[i]  = act_duty_q[i];
            blink_cnt_d[i] = blink_cnt_q[i];
`ifdef LED_SHADOW_EN
            // A write landing on the wrap edge is not visible here yet, so it waits
            // for the following boundary.
            shd_mode_d[i] = wr_sel ? mode_e'(bus.wr_mode) : shd_mode_q[i];
            shd_duty_d[i] = wr_sel ? bus.wr_duty : shd_duty_q[i];
            if (wrap) begin
                act_mode_d[i] = shd_mode_q[i];
                act_duty_d[i] = shd_duty_q[i];
            end
`else
            if (wr_sel) begin
                act_mode_d[i] = mode_e'(bus.wr_mode);
                act_duty_d[i] = bus.wr_duty;
            end
`endif

            // Half-period counting uses the setting in force before this edge.
            if (wrap && act_mode_q[i] == MODE_BLINK) begin
                if (blink_cnt_q[i] == act_duty_q[i]) begin
                    blink_cnt_d[i] = '0;
                    blink_st_d[i]  = ~blink_st_q[i];
                end else begin
                    blink_cnt_d[i] = blink_cnt_q[i] + DUTY_W'(1);
                end
            end

            // Fresh entry into BLINK always starts with a dark half-period.
            if (act_mode_d[i] == MODE_BLINK && act_mode_q[i] != MODE_BLINK) begin
                blink_cnt_d[i] = '0;
                blink_st_d[i]  = 1'b0;
            end

            case (act_mode_q[i])
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_PWM:   led_d[i] = (pwm_cnt_q < act_duty_q[i]);
                MODE_BLINK: led_d[i] = blink_st_q[i];
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            led_q      <= '0;
            blink_st_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                act_mode_q[i]  <= MODE_OFF;
                act_duty_q[i]  <= '0;
                blink_cnt_q[i] <= '0;
`ifdef LED_SHADOW_EN
                shd_mode_q[i]  <= MODE_OFF;
                shd_duty_q[i]  <= '0;
`endif
            end
        end else begin
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            led_q      <= led_d;
            blink_st_q <= blink_st_d;
            for (int i = 0; i < CHANNELS; i++) begin
                act_mode_q[i]  <= act_mode_d[i];
                act_duty_q[i]  <= act_duty_d[i];
                blink_cnt_q[i] <= blink_cnt_d[i];
`ifdef LED_SHADOW_EN
                shd_mode_q[i]  <= shd_mode_d[i];
                shd_duty_q[i]  <= shd_duty_d[i];
`endif
            end
        end
    end

    assign bus.wr_ack = ack_q;
    assign bus.wr_err = err_q;
    assign led        = led_q;

endmodule
